// File: rtl/newstand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : newstand_ctrl
// Brief    : 15c newspaper vending FSM (COLLECT/VEND/REFUND) with nickel refunds.
//            Define NEWSTAND_QUARTER_EN to accept the quarter (3'b100) as 25c.
// Revision : 1.0 - initial release
// ============================================================================
module newstand_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_coin,
    output logic       o_newspaper,
    output logic       o_change
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_REFUND  = 2'd2
    } state_t;

    // Price expressed in nickel units.
    localparam logic [2:0] C_PRICE = 3'd3;

    state_t      r_state;
    logic [1:0]  r_credit;
    logic [2:0]  r_refund;
    logic [2:0]  w_value;
    logic [2:0]  w_sum;

    // Multi-hot (and, without the quarter option, 3'b100) decode to zero value.
    always_comb begin
        w_value = 3'd0;
        case (i_coin)
            3'b001:  w_value = 3'd1;
            3'b010:  w_value = 3'd2;
`ifdef NEWSTAND_QUARTER_EN
            3'b100:  w_value = 3'd5;
`endif
            default: w_value = 3'd0;
        endcase
    end

    assign w_sum = {1'b0, r_credit} + w_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_credit    <= 2'd0;
            r_refund    <= 3'd0;
            o_newspaper <= 1'b0;
            o_change    <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    o_newspaper <= 1'b0;
                    o_change    <= 1'b0;
                    if (w_sum >= C_PRICE) begin
                        r_state     <= S_VEND;
                        o_newspaper <= 1'b1;
                        r_refund    <= w_sum - C_PRICE;
                        r_credit    <= 2'd0;
                    end else begin
                        r_credit    <= w_sum[1:0];
                    end
                end
                S_VEND: begin
                    o_newspaper <= 1'b0;
                    if (r_refund != 3'd0) begin
                        r_state  <= S_REFUND;
                        o_change <= 1'b1;
                        r_refund <= r_refund - 3'd1;
                    end else begin
                        r_state  <= S_COLLECT;
                        o_change <= 1'b0;
                    end
                end
                S_REFUND: begin
                    o_newspaper <= 1'b0;
                    // Each REFUND cycle carries one change pulse; leave once drained.
                    if (r_refund != 3'd0) begin
                        o_change <= 1'b1;
                        r_refund <= r_refund - 3'd1;
                    end else begin
                        o_change <= 1'b0;
                        r_state  <= S_COLLECT;
                    end
                end
                default: begin
                    r_state     <= S_COLLECT;
                    r_credit    <= 2'd0;
                    r_refund    <= 3'd0;
                    o_newspaper <= 1'b0;
                    o_change    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_newstand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_newstand_ctrl
// Brief    : Directed scoreboard bench for newstand_ctrl (quarter cases follow NEWSTAND_QUARTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_newstand_ctrl;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_NICK = 3'b001;
    localparam logic [2:0] C_DIME = 3'b010;
    localparam logic [2:0] C_QUAR = 3'b100;

    logic       clk;
    logic       rst;
    logic [2:0] i_coin;
    logic       o_newspaper;
    logic       o_change;

    int n_cmp;
    int n_mis;
    logic [1:0] sb_q[$];

    newstand_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_coin      (i_coin),
        .o_newspaper (o_newspaper),
        .o_change    (o_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one coin for one edge; the expected outputs for the following cycle are queued and checked.
    task automatic cyc(input string tag, input logic [2:0] c, input logic exp_news, input logic exp_chg);
        logic [1:0] exp;
        @(negedge clk);
        i_coin = c;
        sb_q.push_back({exp_news, exp_chg});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check_bit({tag, ".newspaper"}, o_newspaper, exp[1]);
        check_bit({tag, ".change"}, o_change, exp[0]);
        check_bit({tag, ".exclusive"}, o_newspaper & o_change, 1'b0);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without waiting for an edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst    = 1'b1;
        i_coin = C_NONE;
        #1;
        check_bit({tag, ".rst_newspaper"}, o_newspaper, 1'b0);
        check_bit({tag, ".rst_change"}, o_change, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic three_nickels(input string tag);
        cyc(tag, C_NICK, 1'b0, 1'b0);
        cyc(tag, C_NICK, 1'b0, 1'b0);
        cyc(tag, C_NICK, 1'b1, 1'b0);
        cyc(tag, C_NONE, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_mis  = 0;
        rst    = 1'b1;
        i_coin = C_NONE;
        #3;
        check_bit("reset.newspaper", o_newspaper, 1'b0);
        check_bit("reset.change", o_change, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Three nickels: paper right after the third edge, no change.
        three_nickels("nnn");
        cyc("nnn_idle", C_NONE, 1'b0, 1'b0);

        // Dime + dime = 20c: paper, one nickel back, credit cleared.
        cyc("dd", C_DIME, 1'b0, 1'b0);
        cyc("dd", C_DIME, 1'b1, 1'b0);
        cyc("dd_chg", C_NONE, 1'b0, 1'b1);
        cyc("dd_done", C_NONE, 1'b0, 1'b0);
        three_nickels("dd_credit0");

        // Multi-hot 011 with 5c credit is ignored; dime completes exactly 15c.
        cyc("mh", C_NICK, 1'b0, 1'b0);
        cyc("mh", 3'b011, 1'b0, 1'b0);
        cyc("mh", C_DIME, 1'b1, 1'b0);
        cyc("mh_done", C_NONE, 1'b0, 1'b0);

        // Remaining multi-hot patterns add nothing from zero credit.
        cyc("mh2", 3'b101, 1'b0, 1'b0);
        cyc("mh2", 3'b110, 1'b0, 1'b0);
        cyc("mh2", 3'b111, 1'b0, 1'b0);
        three_nickels("mh2_credit0");

        // Coin during the vend cycle is lost.
        cyc("vlost", C_NICK, 1'b0, 1'b0);
        cyc("vlost", C_DIME, 1'b1, 1'b0);
        cyc("vlost_coin", C_DIME, 1'b0, 1'b0);
        three_nickels("vlost_credit0");

`ifdef NEWSTAND_QUARTER_EN
        // Dime + quarter = 35c: four change pulses; dimes during refund are lost.
        cyc("dq", C_DIME, 1'b0, 1'b0);
        cyc("dq", C_QUAR, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc("dq_chg", C_DIME, 1'b0, 1'b1);
        cyc("dq_done", C_DIME, 1'b0, 1'b0);
        three_nickels("dq_credit0");

        // Quarter alone: two nickels back.
        cyc("q", C_QUAR, 1'b1, 1'b0);
        cyc("q_chg", C_NONE, 1'b0, 1'b1);
        cyc("q_chg", C_NONE, 1'b0, 1'b1);
        cyc("q_done", C_NONE, 1'b0, 1'b0);

        // Reset during the second of four change cycles.
        cyc("rq", C_DIME, 1'b0, 1'b0);
        cyc("rq", C_QUAR, 1'b1, 1'b0);
        cyc("rq_chg1", C_NONE, 1'b0, 1'b1);
        cyc("rq_chg2", C_NONE, 1'b0, 1'b1);
        pulse_reset("rq");
        cyc("rq_after", C_NONE, 1'b0, 1'b0);
        three_nickels("rq_credit0");
`else
        // Quarter is invalid: nothing happens, credit stays as it was.
        cyc("q_idle", C_QUAR, 1'b0, 1'b0);
        cyc("q_idle", C_NONE, 1'b0, 1'b0);
        three_nickels("q_idle_credit0");
        cyc("q_cred", C_NICK, 1'b0, 1'b0);
        cyc("q_cred", C_NICK, 1'b0, 1'b0);
        cyc("q_cred", C_QUAR, 1'b0, 1'b0);
        cyc("q_cred", C_NICK, 1'b1, 1'b0);
        cyc("q_cred_done", C_NONE, 1'b0, 1'b0);

        // Reset during the only change cycle discards the refund.
        cyc("rd", C_DIME, 1'b0, 1'b0);
        cyc("rd", C_DIME, 1'b1, 1'b0);
        cyc("rd_chg", C_NONE, 1'b0, 1'b1);
        pulse_reset("rd");
        cyc("rd_after", C_NONE, 1'b0, 1'b0);
        three_nickels("rd_credit0");
`endif

        // Reset with 10c credit pending: three nickels needed again.
        cyc("rc", C_DIME, 1'b0, 1'b0);
        pulse_reset("rc");
        cyc("rc", C_NICK, 1'b0, 1'b0);
        cyc("rc", C_NICK, 1'b0, 1'b0);
        cyc("rc", C_NICK, 1'b1, 1'b0);
        cyc("rc_done", C_NONE, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
